// File: rtl/key_debouncer_pkg.sv
// Shared types and 50 MHz timing defaults for the key debouncer and its users.
package key_debouncer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESS_CHK = 2'd1,
    ST_HELD      = 2'd2,
    ST_REL_CHK   = 2'd3
  } deb_state_t;

  localparam int DEB_20MS  = 1_000_000;
  localparam int REP_500MS = 25_000_000;
  localparam int REP_100MS = 5_000_000;

  // Debounced level is high in both "pressed" states, including while a release is being qualified.
  function automatic logic level_of(deb_state_t st);
    return (st == ST_HELD) || (st == ST_REL_CHK);
  endfunction

endpackage

// File: rtl/key_debouncer_sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs; 2-edge latency, no backpressure.
// Synchronous active-low clear loads 0 into both stages.
module sync_2ff (
  input  logic i_clk,
  input  logic i_clr,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge i_clk) begin
    if (!i_clr) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/key_debouncer.sv
// Button debouncer: clean level plus press/release strobes, STABLE_CYCLES+2 edges latency, no backpressure.
// Define KEY_DEBOUNCER_AUTOREPEAT_EN to add auto-repeat press strobes while the button stays held.
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = DEB_20MS,
  parameter int CNT_W         = 20,
  parameter int ACTIVE_LOW    = 1,
  parameter int REPEAT_DELAY  = REP_500MS,
  parameter int REPEAT_RATE   = REP_100MS
) (
  input  logic i_clk,
  input  logic i_clr,
  input  logic i_raw,
  output logic o_level,
  output logic o_press_pulse,
  output logic o_release_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  deb_state_t       r_state;
  deb_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_press;
  logic             r_release;
  logic             w_accept_press;
  logic             w_release_nxt;
  logic             w_rep_fire;
  logic             w_raw_norm;
  logic             w_s;

  // Normalizing before the synchronizer lets its zero reset value mean "released" for either polarity.
  assign w_raw_norm = (ACTIVE_LOW != 0) ? ~i_raw : i_raw;

  sync_2ff u_sync (
    .i_clk (i_clk),
    .i_clr (i_clr),
    .i_d   (w_raw_norm),
    .o_q   (w_s)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_accept_press = 1'b0;
    w_release_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_s) begin
          w_state_nxt = ST_PRESS_CHK;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      ST_PRESS_CHK: begin
        if (!w_s) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt    = ST_HELD;
          w_cnt_nxt      = '0;
          w_accept_press = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_HELD: begin
        if (!w_s) begin
          w_state_nxt = ST_REL_CHK;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      ST_REL_CHK: begin
        if (w_s) begin
          w_state_nxt = ST_HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt   = ST_IDLE;
          w_cnt_nxt     = '0;
          w_release_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_clr) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_press   <= w_accept_press | w_rep_fire;
      r_release <= w_release_nxt;
    end
  end

`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

  logic [REP_W-1:0] r_rep_cnt;
  logic             r_rep_first;
  logic             w_rep_hold;
  logic [REP_W-1:0] w_rep_last;

  assign w_rep_hold = (r_state == ST_HELD) && w_s;
  assign w_rep_last = r_rep_first ? REP_W'(REPEAT_DELAY - 1) : REP_W'(REPEAT_RATE - 1);
  assign w_rep_fire = w_rep_hold && (r_rep_cnt == w_rep_last);

  // Any entry into HELD (fresh press or a rejected release) restarts the initial delay.
  always_ff @(posedge i_clk) begin
    if (!i_clr) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b1;
    end else if ((w_state_nxt == ST_HELD) && (r_state != ST_HELD)) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b1;
    end else if (w_rep_fire) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b0;
    end else if (w_rep_hold) begin
      r_rep_cnt <= r_rep_cnt + REP_W'(1);
    end
  end
`else
  assign w_rep_fire = 1'b0;
`endif

  assign o_level         = level_of(r_state);
  assign o_press_pulse   = r_press;
  assign o_release_pulse = r_release;

endmodule

// File: tb/tb_key_debouncer.sv
// Randomized and directed bench for key_debouncer against a run-length reference model.
module tb_key_debouncer;

  localparam int STABLE_CYCLES = 4;
  localparam int CNT_W         = 3;
  localparam int ACTIVE_LOW    = 1;
  localparam int REPEAT_DELAY  = 10;
  localparam int REPEAT_RATE   = 3;

  logic i_clk = 1'b0;
  logic i_clr = 1'b0;
  logic i_raw = 1'b1;
  logic o_level;
  logic o_press_pulse;
  logic o_release_pulse;

  always #5 i_clk = ~i_clk;

  key_debouncer #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W),
    .ACTIVE_LOW    (ACTIVE_LOW),
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_RATE   (REPEAT_RATE)
  ) dut (
    .i_clk           (i_clk),
    .i_clr           (i_clr),
    .i_raw           (i_raw),
    .o_level         (o_level),
    .o_press_pulse   (o_press_pulse),
    .o_release_pulse (o_release_pulse)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: pressed-ness seen two edges late, level flips after
  // STABLE_CYCLES consecutive disagreeing samples.
  bit pipe[$];
  int run;
  bit m_level, m_press, m_rel;
  int since;
  bit first;

  int cnt_press, cnt_rel;

  function automatic bit norm(bit raw);
    return (ACTIVE_LOW != 0) ? !raw : raw;
  endfunction

  task automatic model_edge(input bit clr, input bit raw);
    bit s;
    if (!clr) begin
      pipe = {1'b0, 1'b0};
      run = 0; m_level = 0; m_press = 0; m_rel = 0; since = 0; first = 1;
      return;
    end
    s = pipe.pop_front();
    pipe.push_back(norm(raw));
    m_press = 0;
    m_rel   = 0;
    if (s != m_level) begin
      run++;
      if (run == STABLE_CYCLES) begin
        m_level = s;
        run = 0;
        if (s) begin
          m_press = 1; since = 0; first = 1;
        end else begin
          m_rel = 1;
        end
      end
    end else begin
      if (m_level && run > 0) begin
        since = 0; first = 1;
      end else if (m_level) begin
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
        since++;
        if (since == (first ? REPEAT_DELAY : REPEAT_RATE)) begin
          m_press = 1; since = 0; first = 0;
        end
`endif
      end
      run = 0;
    end
  endtask

  task automatic step(input bit clr, input bit raw);
    i_clr = clr;
    i_raw = raw;
    @(posedge i_clk);
    #1;
    model_edge(clr, raw);
    check("level", int'(o_level), int'(m_level));
    check("press_pulse", int'(o_press_pulse), int'(m_press));
    check("release_pulse", int'(o_release_pulse), int'(m_rel));
    check("strobe_excl", int'(o_press_pulse & o_release_pulse), 0);
    cnt_press += int'(o_press_pulse);
    cnt_rel   += int'(o_release_pulse);
  endtask

  initial begin
    int press_at, rel_at, k, exp_rep;
    pipe = {1'b0, 1'b0};
    run = 0; m_level = 0; m_press = 0; m_rel = 0; since = 0; first = 1;
    cnt_press = 0; cnt_rel = 0;

    // Reset held with the button pressed
    step(0, 0);
    step(0, 0);
    check("rst_level", int'(o_level), 0);
    check("rst_strobes", cnt_press + cnt_rel, 0);

    press_at = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1, 0);
      if (o_press_pulse && press_at == 0) press_at = i;
    end
    check("press_after_reset_edge", press_at, STABLE_CYCLES + 2);

    // Clean release
    rel_at = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1, 1);
      if (o_release_pulse && rel_at == 0) rel_at = i;
    end
    check("clean_release_edge", rel_at, STABLE_CYCLES + 2);

    // Clean press
    press_at = 0; cnt_press = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1, 0);
      if (o_press_pulse && press_at == 0) press_at = i;
    end
    check("clean_press_edge", press_at, STABLE_CYCLES + 2);
    check("clean_press_count", cnt_press, 1);
    check("clean_press_level", int'(o_level), 1);

    // Short glitch while held
    cnt_rel = 0;
    for (int i = 0; i < 3; i++) step(1, 1);
    for (int i = 0; i < 10; i++) step(1, 0);
    check("glitch_no_release", cnt_rel, 0);
    check("glitch_level", int'(o_level), 1);

    // Release interrupted by reset at edge 4
    cnt_rel = 0;
    for (int i = 0; i < 3; i++) step(1, 1);
    step(0, 1);
    check("midcount_rst_level", int'(o_level), 0);
    for (int i = 0; i < 8; i++) step(1, 1);
    check("midcount_rst_no_release", cnt_rel, 0);
    check("midcount_rst_idle", int'(o_level), 0);

    // Bounce then settle pressed
    press_at = 0; cnt_press = 0;
    step(1, 0); step(1, 1); step(1, 0); step(1, 1);
    for (int i = 1; i <= 10; i++) begin
      step(1, 0);
      if (o_press_pulse && press_at == 0) press_at = i;
    end
    check("bounce_press_edge", press_at, STABLE_CYCLES + 2);
    check("bounce_press_count", cnt_press, 1);
    for (int i = 0; i < 10; i++) step(1, 1);

    // Long hold
    cnt_press = 0;
    for (int i = 0; i < 30; i++) step(1, 0);
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
    exp_rep = 6;
`else
    exp_rep = 1;
`endif
    check("hold30_press_count", cnt_press, exp_rep);
    for (int i = 0; i < 10; i++) step(1, 1);

    // Random runs of varied length with occasional resets
    k = 0;
    while (k < 3000) begin
      bit v, c;
      int len;
      v   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 8));
      c   = ($urandom_range(0, 99) != 0);
      for (int j = 0; j < len; j++) step((j == 0) ? c : 1'b1, v);
      k += len;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
